// File: rtl/fp_add_issue_ctrl.sv
// Issue controller for a fixed-latency FP adder: credit flow control, tag pipeline and in-order result FIFO.
// Define FP_ADD_ISSUE_CTRL_SUB_EN to let in_sub flip the sign of op1 on its way to the adder.
`ifndef FP_ADD_LATENCY
`define FP_ADD_LATENCY 2
`endif

module fp_add_issue_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 6,
  parameter int LATENCY    = `FP_ADD_LATENCY,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_op0,
  input  logic [DATA_WIDTH-1:0] in_op1,
  input  logic                  in_sub,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  flush,
  output logic                  fp_enable,
  output logic [DATA_WIDTH-1:0] fp_op0,
  output logic [DATA_WIDTH-1:0] fp_op1,
  input  logic [DATA_WIDTH-1:0] fp_res,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_CREDITS = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, FULL} state_t;
  state_t state;

  logic [LATENCY-1:0]    stage_valid;
  logic [TAG_WIDTH-1:0]  stage_tag [LATENCY];
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  fifo_tag  [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         occupancy, in_flight, occ_next, flight_next;
  logic [CW:0]           credit_next;
  logic                  accept, push, pop;

  // FULL is registered from the same counts that gate issue, so it always matches the live credit total.
  assign in_ready  = ~rst & ~flush & (state != FULL);
  assign accept    = in_valid & in_ready;
  assign fp_enable = accept;
  assign fp_op0    = in_op0;
`ifdef FP_ADD_ISSUE_CTRL_SUB_EN
  assign fp_op1    = in_op1 ^ {in_sub, {(DATA_WIDTH-1){1'b0}}};
`else
  logic unused_sub;
  assign unused_sub = in_sub;
  assign fp_op1    = in_op1;
`endif

  assign push      = stage_valid[LATENCY-1] & ~flush;
  assign out_valid = ~rst & (occupancy != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = fifo_data[rd_ptr];
  assign out_tag   = fifo_tag[rd_ptr];

  always_comb begin
    occ_next    = occupancy;
    flight_next = in_flight;
    if (flush) begin
      occ_next    = '0;
      flight_next = '0;
    end else begin
      if (push && !pop)
        occ_next = occupancy + CW'(1);
      else if (pop && !push)
        occ_next = occupancy - CW'(1);
      if (accept && !push)
        flight_next = in_flight + CW'(1);
      else if (push && !accept)
        flight_next = in_flight - CW'(1);
    end
    credit_next = {1'b0, occ_next} + {1'b0, flight_next};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      occupancy   <= '0;
      in_flight   <= '0;
      state       <= IDLE;
    end else begin
      occupancy <= occ_next;
      in_flight <= flight_next;
      if (flush) begin
        stage_valid <= '0;
        wr_ptr      <= '0;
        rd_ptr      <= '0;
        state       <= IDLE;
      end else begin
        stage_valid[0] <= accept;
        for (int i = 1; i < LATENCY; i++)
          stage_valid[i] <= stage_valid[i-1];
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        if (credit_next >= DEPTH_CREDITS)
          state <= FULL;
        else if (credit_next != '0)
          state <= BUSY;
        else
          state <= IDLE;
      end
    end
  end

  // Payload storage carries no reset; validity lives entirely in the counters and valid bits.
  always_ff @(posedge clk) begin
    stage_tag[0] <= in_tag;
    for (int i = 1; i < LATENCY; i++)
      stage_tag[i] <= stage_tag[i-1];
    if (push) begin
      fifo_data[wr_ptr] <= fp_res;
      fifo_tag[wr_ptr]  <= stage_tag[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_fp_add_issue_ctrl.sv
// Scoreboard bench for fp_add_issue_ctrl: random and directed traffic against a real-arithmetic reference.
module tb_fp_add_issue_ctrl;

  localparam int DW    = 32;
  localparam int TW    = 6;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;

  logic          clk = 0;
  logic          rst, in_valid, in_sub, flush, out_ready;
  logic          in_ready, fp_enable, out_valid;
  logic [DW-1:0] in_op0, in_op1, fp_op0, fp_op1, fp_res, out_data;
  logic [TW-1:0] in_tag, out_tag;

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
  } exp_t;
  exp_t exp_q[$];

  int tests = 0;
  int failed = 0;
  logic last_acc;
  int acc_count;

  always #5 clk = ~clk;

  fp_add_issue_ctrl #(
    .DATA_WIDTH(DW), .TAG_WIDTH(TW), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op0(in_op0), .in_op1(in_op1), .in_sub(in_sub), .in_tag(in_tag),
    .flush(flush), .fp_enable(fp_enable), .fp_op0(fp_op0), .fp_op1(fp_op1),
    .fp_res(fp_res), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag)
  );

  function automatic real sp2real(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:0] == 31'd0) return 0.0;
    e = 11'(b[30:23]) + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] real2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return 32'd0;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] int2sp(input int n);
    return real2sp(real'(n));
  endfunction

  // External adder stand-in: result appears exactly LAT cycles after operands are presented.
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= real2sp(sp2real(fp_op0) + sp2real(fp_op1));
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign fp_res = pipe[LAT-1];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endfunction

  // Monitor: anything the DUT presents must be the oldest outstanding accepted request.
  always @(negedge clk) begin
    if (!rst && !flush && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'd0);
      end else if (out_ready) begin
        exp_t e;
        e = exp_q.pop_front();
        check("out_data", out_data, e.data);
        check("out_tag", 32'(out_tag), 32'(e.tag));
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] op0, input logic [31:0] op1,
                       input logic sub, input logic [TW-1:0] tag,
                       input logic fl, input logic rs, input logic ordy);
    logic exp_ready, acc;
    logic [31:0] eff_op1;
    exp_t e;
    in_valid = v; in_op0 = op0; in_op1 = op1; in_sub = sub; in_tag = tag;
    flush = fl; rst = rs; out_ready = ordy;
    #1;
    exp_ready = !rs && !fl && (exp_q.size() < DEPTH);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    acc = v && in_ready && !fl && !rs;
    check("fp_enable", 32'(fp_enable), 32'(acc));
`ifdef FP_ADD_ISSUE_CTRL_SUB_EN
    eff_op1 = sub ? {~op1[31], op1[30:0]} : op1;
`else
    eff_op1 = op1;
`endif
    if (acc) begin
      check("fp_op0", fp_op0, op0);
      check("fp_op1", fp_op1, eff_op1);
      e.data = real2sp(sp2real(op0) + sp2real(eff_op1));
      e.tag  = tag;
      exp_q.push_back(e);
    end
    if (fl || rs) exp_q.delete();
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    drive(1'b0, 32'd0, 32'd0, 1'b0, '0, 1'b0, 1'b0, ordy);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tag_n, budget;
    rst = 1; in_valid = 0; in_op0 = 0; in_op1 = 0; in_sub = 0; in_tag = 0;
    flush = 0; out_ready = 0;
    repeat (3) begin
      drive(1'b0, 32'd0, 32'd0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
      check("reset_out_valid", 32'(out_valid), 32'd0);
    end

    // 1.0 + 2.0 with tag 5 must surface LAT+1 cycles after acceptance.
    drive(1'b1, 32'h3F800000, 32'h40000000, 1'b0, 6'd5, 1'b0, 1'b0, 1'b1);
    repeat (LAT) idle(1'b1);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_data", out_data, 32'h40400000);
    check("lat_out_tag", 32'(out_tag), 32'd5);
    repeat (3) idle(1'b1);

    // 3.0 with in_sub set: subtraction when the feature is built in, plain add otherwise.
    drive(1'b1, 32'h40400000, 32'h3F800000, 1'b1, 6'd9, 1'b0, 1'b0, 1'b1);
    repeat (LAT + 3) idle(1'b1);

    // Backpressure: only DEPTH credits, then everything drains in order.
    tag_n = 0; acc_count = 0;
    repeat (12) begin
      drive(tag_n < 8, int2sp(tag_n + 1), int2sp(10), 1'b0, TW'(tag_n), 1'b0, 1'b0, 1'b0);
      if (last_acc) begin tag_n++; acc_count++; end
    end
    check("credit_limit_accepts", 32'(acc_count), DEPTH);
    budget = 0;
    while (tag_n < 8 && budget < 40) begin
      drive(1'b1, int2sp(tag_n + 1), int2sp(10), 1'b0, TW'(tag_n), 1'b0, 1'b0, 1'b1);
      if (last_acc) tag_n++;
      budget++;
    end
    check("backpressure_all_issued", 32'(tag_n), 32'd8);
    repeat (LAT + 6) idle(1'b1);
    check("backpressure_drained", 32'(exp_q.size()), 32'd0);

    // Streaming: one issue per cycle must never stall.
    acc_count = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, int2sp(i), int2sp(2 * i), 1'b0, TW'(i), 1'b0, 1'b0, 1'b1);
      if (last_acc) acc_count++;
    end
    check("stream_accepts", 32'(acc_count), 32'd20);
    repeat (LAT + 3) idle(1'b1);

    // Flush with results both buffered and in flight.
    for (int i = 0; i < 3; i++)
      drive(1'b1, int2sp(i), int2sp(7), 1'b0, TW'(i), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (LAT + 3) begin
      idle(1'b1);
      check("flush_out_valid", 32'(out_valid), 32'd0);
    end

    // Reset mid-operation with two buffered and two in flight.
    for (int i = 0; i < 2; i++)
      drive(1'b1, int2sp(i), int2sp(3), 1'b0, TW'(i), 1'b0, 1'b0, 1'b0);
    repeat (LAT + 1) idle(1'b0);
    for (int i = 2; i < 4; i++)
      drive(1'b1, int2sp(i), int2sp(3), 1'b0, TW'(i), 1'b0, 1'b0, 1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    repeat (LAT + 3) begin
      idle(1'b1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
    end

    // Random mix of issue, backpressure and occasional flush.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, int2sp(int'($urandom_range(0, 500))),
            int2sp(int'($urandom_range(0, 500))), 1'($urandom_range(0, 1)),
            TW'($urandom_range(0, 63)), $urandom_range(0, 49) == 0, 1'b0,
            $urandom_range(0, 3) != 0);
    end
    repeat (LAT + 10) idle(1'b1);
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
